// File: rtl/porttest_pkg.sv
// Shared encodings for the port exerciser: pattern modes, FSM states,
// INIT length and the LFSR feedback tap table.
package porttest_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_LFSR  = 2'd0;
  localparam mode_t MODE_WALK  = 2'd1;
  localparam mode_t MODE_ADDR  = 2'd2;
  localparam mode_t MODE_NADDR = 2'd3;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_INIT    = 4'd1;
  localparam logic [3:0] S_WR_REQ  = 4'd2;
  localparam logic [3:0] S_WR_WAIT = 4'd3;
  localparam logic [3:0] S_RESTORE = 4'd4;
  localparam logic [3:0] S_RD_REQ  = 4'd5;
  localparam logic [3:0] S_RD_WAIT = 4'd6;
  localparam logic [3:0] S_RD_NEXT = 4'd7;
  localparam logic [3:0] S_PAUSE   = 4'd8;

  localparam int INITLEN = 16;

  // Maximal-length feedback taps (bit n-1 set for tap n); XOR form, all-zero is the lockup state.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      2:  return 32'h0000_0003;
      3:  return 32'h0000_0006;
      4:  return 32'h0000_000C;
      5:  return 32'h0000_0014;
      6:  return 32'h0000_0030;
      7:  return 32'h0000_0060;
      8:  return 32'h0000_00B8;
      9:  return 32'h0000_0110;
      10: return 32'h0000_0240;
      11: return 32'h0000_0500;
      12: return 32'h0000_0829;
      13: return 32'h0000_100D;
      14: return 32'h0000_2015;
      15: return 32'h0000_6000;
      16: return 32'h0000_D008;
      17: return 32'h0001_2000;
      18: return 32'h0002_0400;
      19: return 32'h0004_0023;
      20: return 32'h0009_0000;
      24: return 32'h00E1_0000;
      default: return 32'h8020_0003;
    endcase
  endfunction

endpackage

// File: rtl/lfsr.sv
// Fibonacci LFSR with a shadow register so a sequence can be replayed:
// save snapshots the current value, restore reloads it.
module lfsr
  import porttest_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             e,
  input  logic             save,
  input  logic             restore,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  logic [WIDTH-1:0] shadow;
  logic             fb;

  assign fb = ^(q & TAPS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q      <= SEED;
      shadow <= SEED;
    end else begin
      if (restore)
        q <= shadow;
      else if (e)
        q <= {q[WIDTH-2:0], fb};
      if (save)
        shadow <= q;
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// Combinational data pattern: the word written at a given pass index and
// the word expected back when it is read.
module pattern_gen
  import porttest_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int IW = 4
) (
  input  logic [1:0]    mode,
  input  logic [IW-1:0] index,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] lfsr_data,
  output logic [DW-1:0] word
);

  logic [DW-1:0] addr_word;

  // Address zero-extended or truncated to the data width.
  for (genvar i = 0; i < DW; i++) begin : g_addr
    if (i < AW) begin : g_bit
      assign addr_word[i] = addr[i];
    end else begin : g_zero
      assign addr_word[i] = 1'b0;
    end
  end

  always_comb begin
    word = lfsr_data;
    case (mode)
      MODE_LFSR:  word = lfsr_data;
      MODE_WALK:  word = DW'(1) << index;
      MODE_ADDR:  word = addr_word;
      MODE_NADDR: word = ~addr_word;
      default:    word = lfsr_data;
    endcase
  end

endmodule

// File: rtl/port_exerciser.sv
// Drives one toggle-handshake RAM port through write-then-readback passes
// and accumulates error statistics.
//
// state     | meaning
// IDLE      | req follows ack, waiting for enable
// INIT      | 16-cycle settle, req follows ack, first pass set up on exit
// WR_REQ    | present address/data, toggle wr_req
// WR_WAIT   | wait for wr_ack; last write rewinds the generators
// RESTORE   | one idle cycle so the restored LFSRs settle
// RD_REQ    | present address, toggle rd_req
// RD_WAIT   | wait for rd_ack, compare and update statistics
// RD_NEXT   | next read or end of pass
// PAUSE     | idle gap between passes
module port_exerciser
  import porttest_pkg::*;
#(
  parameter int ADDRWIDTH  = 16,
  parameter int DATAWIDTH  = 16,
  parameter int CYCLEWIDTH = 6,
  parameter int PAUSELEN   = 63
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic                 clear,
  output logic [ADDRWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] q,
  input  logic [DATAWIDTH-1:0] d,
  output logic                 we,
  output logic                 wr_req,
  input  logic                 wr_ack,
  output logic                 rd_req,
  input  logic                 rd_ack,
  output logic                 busy,
  output logic                 err,
  output logic [DATAWIDTH-1:0] errbits,
  output logic [ADDRWIDTH-1:0] erraddr,
  output logic [31:0]          readcount,
  output logic [31:0]          errorcount,
  output logic [31:0]          passcount
);

  localparam int CW = CYCLEWIDTH + 2;
  localparam int IW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

  logic [3:0]            state;
  logic [CW-1:0]         counter;
  logic [1:0]            mode_r;
  logic [IW-1:0]         walk;
  logic [IW-1:0]         walk_next;
  logic                  first_wr;
  logic                  err_seen;

  logic [ADDRWIDTH-1:0]  addr_q;
  logic [DATAWIDTH-1:0]  data_q;
  logic [CYCLEWIDTH-1:0] pass_q;
  logic [DATAWIDTH-1:0]  pattern;
  logic [DATAWIDTH-1:0]  diff;

  logic step_gen, save_gen, restore_gen, step_pass;
  logic done_wr, done_rd;

  assign done_wr   = (wr_req == wr_ack);
  assign done_rd   = (rd_req == rd_ack);
  assign walk_next = (walk == IW'(DATAWIDTH - 1)) ? '0 : walk + IW'(1);
  assign diff      = d ^ pattern;

  always_comb begin
    step_gen    = 1'b0;
    save_gen    = 1'b0;
    restore_gen = 1'b0;
    step_pass   = 1'b0;
    case (state)
      S_INIT:    save_gen = (counter == '0);
      S_WR_REQ:  step_gen = 1'b1;
      S_WR_WAIT: begin
        restore_gen = done_wr && (counter == '0);
        step_pass   = done_wr && (counter == '0);
      end
      S_RD_WAIT: step_gen = done_rd && (counter != '0);
      S_PAUSE:   save_gen = (counter == '0) && enable;
      default:   ;
    endcase
  end

  lfsr #(.WIDTH(ADDRWIDTH)) u_addr_lfsr (
    .clk(clk), .reset_n(reset_n), .e(step_gen),
    .save(save_gen), .restore(restore_gen), .q(addr_q)
  );

  lfsr #(.WIDTH(DATAWIDTH)) u_data_lfsr (
    .clk(clk), .reset_n(reset_n), .e(step_gen),
    .save(save_gen), .restore(restore_gen), .q(data_q)
  );

  // Nonzero LFSR values 1..2^N-1 give passes of 2..2^N transactions.
  lfsr #(.WIDTH(CYCLEWIDTH)) u_pass_lfsr (
    .clk(clk), .reset_n(reset_n), .e(step_pass),
    .save(1'b0), .restore(1'b0), .q(pass_q)
  );

  pattern_gen #(.AW(ADDRWIDTH), .DW(DATAWIDTH), .IW(IW)) u_pattern (
    .mode(mode_r), .index(walk), .addr(addr_q), .lfsr_data(data_q), .word(pattern)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      counter    <= '0;
      mode_r     <= MODE_LFSR;
      walk       <= '0;
      first_wr   <= 1'b0;
      err_seen   <= 1'b0;
      a          <= '0;
      q          <= '0;
      we         <= 1'b0;
      wr_req     <= 1'b0;
      rd_req     <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      errbits    <= '0;
      erraddr    <= '0;
      readcount  <= '0;
      errorcount <= '0;
      passcount  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          wr_req <= wr_ack;
          rd_req <= rd_ack;
          if (enable) begin
            counter <= CW'(INITLEN - 1);
            busy    <= 1'b1;
            state   <= S_INIT;
          end
        end
        S_INIT: begin
          wr_req <= wr_ack;
          rd_req <= rd_ack;
          if (counter != '0) begin
            counter <= counter - CW'(1);
          end else begin
            counter  <= CW'(pass_q);
            mode_r   <= mode;
            walk     <= '0;
            first_wr <= 1'b1;
            state    <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          a        <= addr_q;
          q        <= pattern;
          we       <= 1'b1;
          wr_req   <= ~wr_ack;
          walk     <= walk_next;
          first_wr <= 1'b0;
          if (first_wr)
            err <= 1'b0;
          state    <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (done_wr) begin
            rd_req <= rd_ack;
            if (counter != '0) begin
              counter <= counter - CW'(1);
              state   <= S_WR_REQ;
            end else begin
              counter <= CW'(pass_q);
              walk    <= '0;
              we      <= 1'b0;
              state   <= S_RESTORE;
            end
          end
        end
        S_RESTORE: state <= S_RD_REQ;
        S_RD_REQ: begin
          a      <= addr_q;
          rd_req <= ~rd_ack;
          state  <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (done_rd) begin
            readcount <= readcount + 32'd1;
            errbits   <= errbits | diff;
            if (diff != '0) begin
              errorcount <= errorcount + 32'd1;
              err        <= 1'b1;
              if (!err_seen) begin
                erraddr  <= a;
                err_seen <= 1'b1;
              end
            end
            if (counter != '0)
              walk <= walk_next;
            state <= S_RD_NEXT;
          end
        end
        S_RD_NEXT: begin
          if (counter != '0) begin
            counter <= counter - CW'(1);
            state   <= S_RD_REQ;
          end else begin
            passcount <= passcount + 32'd1;
            counter   <= CW'(PAUSELEN);
            state     <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (counter != '0) begin
            counter <= counter - CW'(1);
          end else if (enable) begin
            counter  <= CW'(pass_q);
            mode_r   <= mode;
            walk     <= '0;
            first_wr <= 1'b1;
            state    <= S_WR_REQ;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase

      // Clear takes priority over any statistics update in the same cycle.
      if (clear) begin
        errbits    <= '0;
        erraddr    <= '0;
        readcount  <= '0;
        errorcount <= '0;
        passcount  <= '0;
        err_seen   <= 1'b0;
      end
    end
  end

endmodule
